// File: rtl/overload_dac_out.sv
// Overload loop DAC output stage: converts the signed PID result to an offset-binary
// code, saturates and slew-limits it, and writes it to a 16-bit SPI DAC (mode 0, MSB first).
module overload_dac_out #(
  parameter int CLK_DIV       = 4,
  parameter int UPDATE_PERIOD = 1000,
  parameter int OFFSET        = 32768,
  parameter int SLEW_STEP     = 256,
  parameter int IDLE_CODE     = 32768
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        overload_motor_en_i,
  input  logic [31:0] overload_pid_result_i,
  output logic        dac_sclk_o,
  output logic        dac_csn_o,
  output logic        dac_sdi_o,
  output logic [15:0] dac_code_o,
  output logic        dac_busy_o,
  output logic        sat_hi_o,
  output logic        sat_lo_o,
  output logic [1:0]  state_dbg_o
);

  localparam int TW = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q;
  logic [DW-1:0]   div_q;
  logic [3:0]      bit_q;
  logic [15:0]     shift_q;
  logic [15:0]     cur_q;
  logic [15:0]     next_q;
  logic [15:0]     target_q;
  logic            first_q;

  logic            tick;
  logic            phase_end;
  logic            last_fall;
  logic [33:0]     sum;
  logic [15:0]     cap_target;
  logic            cap_hi;
  logic            cap_lo;
  logic [16:0]     cur17;
  logic [16:0]     tgt17;
  logic [16:0]     step17;
  logic [16:0]     up17;
  logic [15:0]     slew;
  logic            skip;

  assign tick      = (timer_q == TW'(UPDATE_PERIOD - 1));
  assign phase_end = (div_q == DW'(CLK_DIV - 1));
  assign last_fall = dac_sclk_o && phase_end && (bit_q == 4'd15);

  // Target capture: sign-extend to 34 bits so the offset add can never overflow.
  assign sum = {{2{overload_pid_result_i[31]}}, overload_pid_result_i} + 34'(OFFSET);

  always_comb begin
    cap_target = 16'(IDLE_CODE);
    cap_hi     = 1'b0;
    cap_lo     = 1'b0;
    if (overload_motor_en_i) begin
      if (sum[33]) begin
        cap_target = 16'h0000;
        cap_lo     = 1'b1;
      end else if (|sum[32:16]) begin
        cap_target = 16'hffff;
        cap_hi     = 1'b1;
      end else begin
        cap_target = sum[15:0];
      end
    end
  end

  // Slew limit in 17 bits: the extra bit keeps cur+step and target+step from wrapping.
  assign cur17  = {1'b0, cur_q};
  assign tgt17  = {1'b0, target_q};
  assign step17 = 17'(SLEW_STEP);
  assign up17   = cur17 + step17;

  always_comb begin
    slew = target_q;
    if (tgt17 > up17) begin
      slew = up17[15:0];
    end else if ((tgt17 + step17) < cur17) begin
      slew = cur_q - 16'(SLEW_STEP);
    end
  end

  assign skip = (slew == cur_q) && !first_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (tick) state_d = S_LOAD;
      S_LOAD:  state_d = skip ? S_IDLE : S_SHIFT;
      S_SHIFT: if (last_fall) state_d = S_DONE;
      S_DONE:  if (phase_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dac_busy_o  = (state_q != S_IDLE);
    state_dbg_o = state_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      timer_q    <= '0;
      div_q      <= '0;
      bit_q      <= 4'd0;
      shift_q    <= 16'h0000;
      cur_q      <= 16'(IDLE_CODE);
      next_q     <= 16'(IDLE_CODE);
      target_q   <= 16'(IDLE_CODE);
      first_q    <= 1'b1;
      dac_sclk_o <= 1'b0;
      dac_csn_o  <= 1'b1;
      dac_sdi_o  <= 1'b0;
      dac_code_o <= 16'(IDLE_CODE);
      sat_hi_o   <= 1'b0;
      sat_lo_o   <= 1'b0;
    end else begin
      timer_q <= tick ? '0 : timer_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          if (tick) begin
            target_q <= cap_target;
            sat_hi_o <= cap_hi;
            sat_lo_o <= cap_lo;
          end
        end
        S_LOAD: begin
          if (!skip) begin
            next_q     <= slew;
            shift_q    <= slew;
            dac_sdi_o  <= slew[15];
            dac_csn_o  <= 1'b0;
            dac_sclk_o <= 1'b0;
            first_q    <= 1'b0;
            div_q      <= '0;
            bit_q      <= 4'd0;
          end
        end
        S_SHIFT: begin
          if (phase_end) begin
            div_q <= '0;
            if (!dac_sclk_o) begin
              dac_sclk_o <= 1'b1;
            end else if (bit_q == 4'd15) begin
              dac_sclk_o <= 1'b0;
              dac_csn_o  <= 1'b1;
              dac_sdi_o  <= 1'b0;
              cur_q      <= next_q;
              dac_code_o <= next_q;
            end else begin
              dac_sclk_o <= 1'b0;
              bit_q      <= bit_q + 4'd1;
              shift_q    <= {shift_q[14:0], 1'b0};
              dac_sdi_o  <= shift_q[14];
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        S_DONE: begin
          div_q <= div_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_overload_dac_out.sv
// Bench for overload_dac_out: one instance with a full-range slew step and one with a
// 256-code step; an SPI monitor decodes every frame and checks it against exp_q.
module tb_overload_dac_out;

  localparam int CLK_DIV = 4;
  localparam int UP      = 200;
  localparam int W       = 17;

  logic        clk;
  logic [1:0]  rst_n;
  logic [1:0]  en;
  logic [31:0] pid [2];
  logic [1:0]  sclk_w, csn_w, sdi_w, busy_w, hi_w, lo_w;
  logic [15:0] code_w [2];
  logic [1:0]  st_w [2];

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  overload_dac_out #(.CLK_DIV(CLK_DIV), .UPDATE_PERIOD(UP), .OFFSET(32768),
                     .SLEW_STEP(65535), .IDLE_CODE(32768)) u_fast (
    .clk_i(clk), .rst_n_i(rst_n[0]), .overload_motor_en_i(en[0]),
    .overload_pid_result_i(pid[0]), .dac_sclk_o(sclk_w[0]), .dac_csn_o(csn_w[0]),
    .dac_sdi_o(sdi_w[0]), .dac_code_o(code_w[0]), .dac_busy_o(busy_w[0]),
    .sat_hi_o(hi_w[0]), .sat_lo_o(lo_w[0]), .state_dbg_o(st_w[0])
  );

  overload_dac_out #(.CLK_DIV(CLK_DIV), .UPDATE_PERIOD(UP), .OFFSET(32768),
                     .SLEW_STEP(256), .IDLE_CODE(32768)) u_slow (
    .clk_i(clk), .rst_n_i(rst_n[1]), .overload_motor_en_i(en[1]),
    .overload_pid_result_i(pid[1]), .dac_sclk_o(sclk_w[1]), .dac_csn_o(csn_w[1]),
    .dac_sdi_o(sdi_w[1]), .dac_code_o(code_w[1]), .dac_busy_o(busy_w[1]),
    .sat_hi_o(hi_w[1]), .sat_lo_o(lo_w[1]), .state_dbg_o(st_w[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  // monitor: decode SPI frames, pop and compare at chip-select release
  task automatic monitor_loop();
    int          in_frame [2] = '{0, 0};
    int          low [2];
    int          nbits [2];
    logic [15:0] word [2];
    logic        sbad [2];
    logic        psclk [2];
    logic        psdi [2];
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (!rst_n[g]) begin
          in_frame[g] = 0;
        end else if (in_frame[g] == 0) begin
          if (!csn_w[g]) begin
            in_frame[g] = 1;
            low[g]      = 1;
            nbits[g]    = 0;
            word[g]     = 16'h0000;
            sbad[g]     = 1'b0;
            psclk[g]    = sclk_w[g];
            psdi[g]     = sdi_w[g];
          end
        end else if (!csn_w[g]) begin
          low[g]++;
          if (!psclk[g] && sclk_w[g]) begin
            word[g] = {word[g][14:0], sdi_w[g]};
            nbits[g]++;
          end
          if ((sdi_w[g] != psdi[g]) && !(psclk[g] && !sclk_w[g])) sbad[g] = 1'b1;
          psclk[g] = sclk_w[g];
          psdi[g]  = sdi_w[g];
        end else begin
          in_frame[g] = 0;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame: inst %0d got 0x%0h expected no frame", g, word[g]);
          end else begin
            e = exp_q.pop_front();
            chk("frame_inst", 32'(g), 32'(e[16]));
            chk("frame_word", 32'(word[g]), 32'(e[15:0]));
            chk("frame_bits", 32'(nbits[g]), 32'd16);
            chk("csn_low_cycles", 32'(low[g]), 32'(32 * CLK_DIV));
            chk("sdi_stable", 32'(sbad[g]), 32'd0);
            chk("dac_code_at_end", 32'(code_w[g]), 32'(e[15:0]));
          end
        end
      end
    end
  endtask

  // driver: wait for one update tick (busy pulse) and report its width
  task wait_tick(input int g, output int width);
    int n;
    n = 0;
    width = 0;
    while (!busy_w[g] && n < 3 * UP) begin
      @(negedge clk);
      n++;
    end
    if (!busy_w[g]) begin
      n_checks++;
      n_fail++;
      $display("FAIL tick_timeout: inst %0d got no busy expected busy within %0d cycles", g, 3 * UP);
      return;
    end
    while (busy_w[g] && width < 2 * UP) begin
      @(negedge clk);
      width++;
    end
  endtask

  task release_rst(input int g);
    @(posedge clk);
    #2 rst_n[g] = 1'b1;
  endtask

  initial begin
    int          w;
    int          n;
    int          rises;
    logic        ps;
    logic [15:0] c;

    rst_n = 2'b00;
    en    = 2'b00;
    pid[0] = 32'h0;
    pid[1] = 32'h0;
    fork
      monitor_loop();
    join_none

    repeat (3) @(negedge clk);
    chk("rst_csn", 32'(csn_w[0]), 32'd1);
    chk("rst_sclk", 32'(sclk_w[0]), 32'd0);
    chk("rst_sdi", 32'(sdi_w[0]), 32'd0);
    chk("rst_busy", 32'(busy_w[0]), 32'd0);
    chk("rst_sat", 32'({hi_w[0], lo_w[0]}), 32'd0);
    chk("rst_code", 32'(code_w[0]), 32'h8000);
    chk("rst_state", 32'(st_w[0]), 32'd0);

    // first tick after reset always sends, second tick with unchanged code does not
    release_rst(0);
    exp_q.push_back({1'b0, 16'h8000});
    wait_tick(0, w);
    chk("t1_frame_busy_width", 32'(w), 32'(1 + 32 * CLK_DIV + CLK_DIV));
    wait_tick(0, w);
    chk("t1_skip_busy_width", 32'(w), 32'd1);
    chk("t1_skip_csn", 32'(csn_w[0]), 32'd1);

    // saturation both ways
    en[0]  = 1'b1;
    pid[0] = 32'h0001_0000;
    exp_q.push_back({1'b0, 16'hffff});
    wait_tick(0, w);
    chk("t2_code_hi", 32'(code_w[0]), 32'hffff);
    chk("t2_sat_hi", 32'({hi_w[0], lo_w[0]}), 32'b10);
    pid[0] = 32'hffff_0000;
    exp_q.push_back({1'b0, 16'h0000});
    wait_tick(0, w);
    chk("t2_code_lo", 32'(code_w[0]), 32'h0000);
    chk("t2_sat_lo", 32'({hi_w[0], lo_w[0]}), 32'b01);

    // bit order
    pid[0] = 32'h0000_25c3;
    exp_q.push_back({1'b0, 16'ha5c3});
    wait_tick(0, w);
    chk("t3_code", 32'(code_w[0]), 32'ha5c3);
    chk("t3_sat", 32'({hi_w[0], lo_w[0]}), 32'd0);

    // reset during the 9th bit of a frame
    pid[0] = 32'h0000_1234;
    n = 0;
    rises = 0;
    ps = 1'b0;
    while (!(rises == 8 && !sclk_w[0]) && n < 2 * UP) begin
      @(negedge clk);
      n++;
      if (!ps && sclk_w[0]) rises++;
      ps = sclk_w[0];
    end
    chk("t6_reached_bit9", 32'(rises), 32'd8);
    #1;
    en[0]    = 1'b0;
    rst_n[0] = 1'b0;
    #1;
    chk("t6_abort_csn", 32'(csn_w[0]), 32'd1);
    chk("t6_abort_sclk", 32'(sclk_w[0]), 32'd0);
    chk("t6_abort_code", 32'(code_w[0]), 32'h8000);
    repeat (3) @(negedge clk);
    release_rst(0);
    exp_q.push_back({1'b0, 16'h8000});
    wait_tick(0, w);
    chk("t6_resend_code", 32'(code_w[0]), 32'h8000);

    // slew up to 40000 in steps of 256
    release_rst(1);
    exp_q.push_back({1'b1, 16'h8000});
    wait_tick(1, w);
    en[1]  = 1'b1;
    pid[1] = 32'd7232;
    for (int k = 1; k <= 29; k++) begin
      c = (k < 29) ? 16'(32768 + 256 * k) : 16'd40000;
      exp_q.push_back({1'b1, c});
      wait_tick(1, w);
      chk("t4_code", 32'(code_w[1]), 32'(c));
    end
    wait_tick(1, w);
    chk("t4_settled_busy_width", 32'(w), 32'd1);
    chk("t4_sat", 32'({hi_w[1], lo_w[1]}), 32'd0);

    // disable: step back down to idle code
    en[1] = 1'b0;
    for (int k = 1; k <= 29; k++) begin
      c = (k < 29) ? 16'(40000 - 256 * k) : 16'd32768;
      exp_q.push_back({1'b1, c});
      wait_tick(1, w);
      chk("t5_code", 32'(code_w[1]), 32'(c));
      chk("t5_sat", 32'({hi_w[1], lo_w[1]}), 32'd0);
    end
    wait_tick(1, w);
    chk("t5_settled_busy_width", 32'(w), 32'd1);

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
